// File: rtl/fetch_align_buf_pkg.sv
// Shared IFU constants: RVC quadrants, expanded opcodes, instruction length.
package fetch_align_buf_pkg;

    localparam logic [1:0] RVC_OPCODE_Q0 = 2'b00;
    localparam logic [1:0] RVC_OPCODE_Q1 = 2'b01;
    localparam logic [1:0] RVC_OPCODE_Q2 = 2'b10;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic {
        LEN_16 = 1'b0,
        LEN_32 = 1'b1
    } instr_len_e;

endpackage

// File: rtl/fetch_align_buf_rvc_expand.sv
// Combinational RV32C to RV32I expander. Illegal encodings produce all-zero output.
module rvc_expand
    import fetch_align_buf_pkg::*;
#(
    parameter bit C_EXT = 1'b1
) (
    input  logic [15:0] hw,
    output logic [31:0] instr,
    output logic        illegal
);

    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [31:0] raw;
    logic        ill;

    assign rd   = hw[11:7];
    assign rs2  = hw[6:2];
    assign rdp  = {2'b01, hw[4:2]};
    assign rs1p = {2'b01, hw[9:7]};

    // Decode by quadrant and funct3; F/D and RV64-only slots fall to illegal.
    always_comb begin
        raw = '0;
        ill = 1'b0;
        case (hw[1:0])
            RVC_OPCODE_Q0: begin
                case (hw[15:13])
                    3'b000: begin
                        raw = {2'b00, hw[10:7], hw[12:11], hw[5], hw[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
                        ill = (hw[12:5] == 8'd0);
                    end
                    3'b010: raw = {5'b0, hw[5], hw[12:10], hw[6], 2'b00, rs1p, 3'b010, rdp, LOAD};
                    3'b110: raw = {5'b0, hw[5], hw[12], rdp, rs1p, 3'b010, hw[11:10], hw[6], 2'b00, STORE};
                    default: ill = 1'b1;
                endcase
            end
            RVC_OPCODE_Q1: begin
                case (hw[15:13])
                    3'b000: raw = {{7{hw[12]}}, hw[6:2], rd, 3'b000, rd, OP_IMM};
                    3'b001: raw = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3],
                                   hw[12], {8{hw[12]}}, 5'd1, JAL};
                    3'b010: raw = {{7{hw[12]}}, hw[6:2], 5'd0, 3'b000, rd, OP_IMM};
                    3'b011: begin
                        if (rd == 5'd2) begin
                            raw = {{3{hw[12]}}, hw[4:3], hw[5], hw[2], hw[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
                        end else begin
                            raw = {{15{hw[12]}}, hw[6:2], rd, LUI};
                        end
                        ill = ({hw[12], hw[6:2]} == 6'd0);
                    end
                    3'b100: begin
                        case (hw[11:10])
                            2'b00: begin
                                raw = {7'b0000000, hw[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                                ill = hw[12];
                            end
                            2'b01: begin
                                raw = {7'b0100000, hw[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                                ill = hw[12];
                            end
                            2'b10: raw = {{7{hw[12]}}, hw[6:2], rs1p, 3'b111, rs1p, OP_IMM};
                            default: begin
                                case (hw[6:5])
                                    2'b00:   raw = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP};
                                    2'b01:   raw = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP};
                                    2'b10:   raw = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP};
                                    default: raw = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP};
                                endcase
                                ill = hw[12];
                            end
                        endcase
                    end
                    3'b101: raw = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3],
                                   hw[12], {8{hw[12]}}, 5'd0, JAL};
                    3'b110: raw = {hw[12], {3{hw[12]}}, hw[6:5], hw[2], 5'd0, rs1p, 3'b000,
                                   hw[11:10], hw[4:3], hw[12], BRANCH};
                    default: raw = {hw[12], {3{hw[12]}}, hw[6:5], hw[2], 5'd0, rs1p, 3'b001,
                                    hw[11:10], hw[4:3], hw[12], BRANCH};
                endcase
            end
            RVC_OPCODE_Q2: begin
                case (hw[15:13])
                    3'b000: begin
                        raw = {7'b0000000, hw[6:2], rd, 3'b001, rd, OP_IMM};
                        ill = hw[12];
                    end
                    3'b010: begin
                        raw = {4'b0000, hw[3:2], hw[12], hw[6:4], 2'b00, 5'd2, 3'b010, rd, LOAD};
                        ill = (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!hw[12]) begin
                            if (rs2 == 5'd0) begin
                                raw = {12'b0, rd, 3'b000, 5'd0, JALR};
                                ill = (rd == 5'd0);
                            end else begin
                                raw = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP};
                            end
                        end else if (rs2 == 5'd0) begin
                            raw = (rd == 5'd0) ? EBREAK_INSTR : {12'b0, rd, 3'b000, 5'd1, JALR};
                        end else begin
                            raw = {7'b0000000, rs2, rd, 3'b000, rd, OP};
                        end
                    end
                    3'b110: raw = {4'b0000, hw[8:7], hw[12], rs2, 5'd2, 3'b010, hw[11:9], 2'b00, STORE};
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (!C_EXT) begin
            ill = 1'b1;
        end
    end

    assign illegal = ill;
    assign instr   = ill ? 32'd0 : raw;

endmodule

// File: rtl/fetch_align_buf.sv
// Fetch alignment buffer: halfword queue that realigns fetch words into
// whole (expanded) instructions, with halfword-granular redirect.
module fetch_align_buf
    import fetch_align_buf_pkg::*;
#(
    parameter int          DEPTH_HW = 6,
    parameter bit          C_EXT    = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        compressed,
    output logic        illegal,
    output logic [31:0] pc_out
);

    localparam int CNT_W = $clog2(DEPTH_HW + 1);

    logic [15:0]      hw_q [DEPTH_HW];
    logic [15:0]      hw_d [DEPTH_HW];
    logic [15:0]      ext  [DEPTH_HW + 2];
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_q, pc_d;
    logic             skip_lo_q, skip_lo_d;

    instr_len_e       head_len;
    logic             push, pop;
    logic [CNT_W-1:0] pop_n, push_n, surv;
    logic [31:0]      exp_instr;
    logic             exp_illegal;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = redirect_pc[0];

    assign head_len  = (hw_q[0][1:0] == 2'b11) ? LEN_32 : LEN_16;
    assign in_ready  = (count_q <= CNT_W'(DEPTH_HW - 2));
    assign out_valid = (count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && (head_len == LEN_16));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    rvc_expand #(.C_EXT(C_EXT)) u_rvc_expand (
        .hw      (hw_q[0]),
        .instr   (exp_instr),
        .illegal (exp_illegal)
    );

    // Queue shift on pop, then append pushed halfwords behind the survivors.
    always_comb begin
        pop_n = '0;
        if (pop) begin
            pop_n = (head_len == LEN_32) ? CNT_W'(2) : CNT_W'(1);
        end
        push_n = '0;
        if (push) begin
            push_n = skip_lo_q ? CNT_W'(1) : CNT_W'(2);
        end
        surv = count_q - pop_n;
        for (int i = 0; i < DEPTH_HW; i++) begin
            ext[i] = hw_q[i];
        end
        ext[DEPTH_HW]     = '0;
        ext[DEPTH_HW + 1] = '0;
        for (int i = 0; i < DEPTH_HW; i++) begin
            if (pop_n == CNT_W'(2)) begin
                hw_d[i] = ext[i + 2];
            end else if (pop_n == CNT_W'(1)) begin
                hw_d[i] = ext[i + 1];
            end else begin
                hw_d[i] = ext[i];
            end
            if (push && (surv == CNT_W'(i))) begin
                hw_d[i] = skip_lo_q ? in_word[31:16] : in_word[15:0];
            end
            if (push && !skip_lo_q && ((surv + CNT_W'(1)) == CNT_W'(i))) begin
                hw_d[i] = in_word[31:16];
            end
        end
    end

    // Count, PC and skip flag; a redirect discards this cycle's push and pop.
    always_comb begin
        count_d   = count_q - pop_n + push_n;
        pc_d      = pc_q;
        skip_lo_d = push ? 1'b0 : skip_lo_q;
        if (pop) begin
            pc_d = pc_q + ((head_len == LEN_32) ? 32'd4 : 32'd2);
        end
        if (redirect_valid) begin
            count_d   = '0;
            pc_d      = {redirect_pc[31:1], 1'b0};
            skip_lo_d = redirect_pc[1];
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            pc_q      <= RESET_PC;
            skip_lo_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

    // Halfword storage; contents beyond count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
    end

    // Head instruction: 32-bit passes through, 16-bit goes through the expander.
    always_comb begin
        instr_out  = exp_instr;
        compressed = 1'b1;
        illegal    = exp_illegal;
        if (head_len == LEN_32) begin
            instr_out  = {hw_q[1], hw_q[0]};
            compressed = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign pc_out = pc_q;

endmodule
